fetch: RTL
==========

# fetch

Instruction fetch stage feeding the decode stage of the dual-issue core. Drives the synchronous-read instruction memory, tracks the fetch PC, and presents one 64-bit bundle per cycle (upper slot [63:32], lower slot [31:0]) with its PC. Absorbs decode's interlock via a one-entry skid buffer, redirects on decode's branch pulse, and stops fetching once an `End` bundle has been accepted.

## Interface
- `RESET_PC`, default 32'h0: first address fetched after reset.
- `IMEM_ADDR_W`, default 15: instruction memory word-address width.
- `NOP_WORD`, default {Nop, 26'b0, Nop, 26'b0}: bubble bundle, opcodes from inst_package.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `interlock`  in  1  decode stall; decode does not accept this cycle.
- `branch_flag`  in  1  one-cycle redirect pulse from decode.
- `branch_pc`  in  32  redirect target, valid with `branch_flag`.
- `imem_en`  out  1  memory read enable (combinational).
- `imem_addr`  out  IMEM_ADDR_W  read word address (combinational).
- `imem_dout`  in  64  read data; valid exactly one cycle after an enabled read, undefined otherwise.
- `pc`  out  32  PC of bundle presented to decode (registered).
- `inst`  out  64  bundle presented to decode (registered).
- `halted`  out  1  set once an `End` bundle is accepted.

## Operation
- State: `nxt` (next issue address), `f_pc`/`f_valid` (read in flight, data on `imem_dout` this cycle), `sk_pc`/`sk_inst`/`sk_valid` (skid), `pc`/`inst` (output), `halted`.
- Accept = ~interlock & ~branch_flag (matches decode's accept condition).
- Priority per cycle: rstn low > halted > branch_flag > interlock > normal.
- Reset: `nxt`=RESET_PC, `f_valid`=0, `sk_valid`=0, `pc`=0, `inst`=NOP_WORD, `halted`=0; `imem_en`=0 while rstn low.
- Branch (branch_flag=1, interlock ignored): `imem_en`=1, `imem_addr`=branch_pc; `f_pc`<=branch_pc, `f_valid`<=1, `nxt`<=branch_pc+1; `sk_valid`<=0; `pc`<=0, `inst`<=NOP_WORD. In-flight and skid words are discarded.
- Hold (interlock=1, branch_flag=0): `imem_en`=0; `pc`/`inst`/`nxt` unchanged; if `f_valid`, capture {f_pc, imem_dout} into skid, `sk_valid`<=1; `f_valid`<=0.
- Normal (accept): `imem_en`=1, `imem_addr`=nxt; `f_pc`<=nxt, `f_valid`<=1, `nxt`<=nxt+1. Output source: skid if `sk_valid` (then `sk_valid`<=0), else {f_pc, imem_dout} if `f_valid`, else {0, NOP_WORD}.
- With a valid skid on release, the in-flight read is the address after the skid word. Order is preserved, with no bubble.
- Halt: in an accept cycle where `inst[63:58]`==End, `halted`<=1; that cycle `imem_en`=0 and `pc`<=0, `inst`<=NOP_WORD.
- While halted: `imem_en`=0, outputs hold {0, NOP_WORD}, `branch_flag`/`interlock` are ignored; exit only via reset.
- Arithmetic: `nxt` is 32-bit and wraps 32'hFFFFFFFF→0; `imem_addr` = nxt[IMEM_ADDR_W-1:0] (truncation, no range check).

## Timing
- First bundle: rstn high at edge E0; RESET_PC is issued in cycle after E0; `inst`=mem[RESET_PC] after edge E0+2.
- Steady state: one bundle per cycle; `pc` increments by 1 each accept.
- Redirect: `branch_flag` in cycle t gives `inst`=NOP_WORD after edge t, and `inst`=mem[branch_pc] with `pc`=branch_pc after edge t+1.
- Interlock of N cycles: outputs are frozen N cycles; the next bundle appears the edge after interlock falls.
- Only one read is ever in flight; the skid holds at most one word. Skid overflow is impossible because hold disables reads.
- Reset mid-operation: all state is reinitialised on that edge; skid and in-flight data are lost.

## Test plan
- Reset, mem[i]=i, no stalls → after 2 edges `pc`=0, `inst`=0; then `pc`/`inst` = 1, 2, 3 on successive edges.
- Interlock high 3 cycles while `pc`=5 → `pc`=5 held 3 cycles; after release `pc`=6, 7 with no gap or duplicate; `imem_en`=0 during hold.
- `branch_flag` with branch_pc=0x100 while `pc`=8 → next `inst`=NOP_WORD, `pc`=0; following edge `pc`=0x100, then 0x101.
- `branch_flag` and `interlock` together with skid full → branch wins; skid word is never emitted; target arrives 2 edges later.
- End bundle at address 4 → accepted, `halted`=1, `imem_en` stays 0, `inst`=NOP_WORD thereafter; a later `branch_flag` has no effect; reset restarts at 0.
- Start at RESET_PC=32'hFFFFFFFF → `pc` sequence 0xFFFFFFFF, 0x0; `imem_addr` is the low 15 bits.

Source files
------------

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage bundle: decode handshake, instruction memory port and presented bundle
interface fetch_if #(
    parameter int IMEM_ADDR_W = 15
);
    logic                   interlock;
    logic                   branch_flag;
    logic [31:0]            branch_pc;
    logic                   imem_en;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [63:0]            imem_dout;
    logic [31:0]            pc;
    logic [63:0]            inst;
    logic                   halted;

    modport master (
        input  interlock, branch_flag, branch_pc, imem_dout,
        output imem_en, imem_addr, pc, inst, halted
    );

    modport slave (
        output interlock, branch_flag, branch_pc, imem_dout,
        input  imem_en, imem_addr, pc, inst, halted
    );
endinterface

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage with one-entry skid, branch redirect and End halt
module fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          IMEM_ADDR_W = 15,
    parameter logic [5:0]  NOP_OP      = 6'h01,
    parameter logic [5:0]  END_OP      = 6'h3F,
    parameter logic [63:0] NOP_WORD    = {NOP_OP, 26'b0, NOP_OP, 26'b0}
) (
    input  logic     clk,
    input  logic     rstn,
    fetch_if.master  bus
);
    logic [31:0] nxt_q, nxt_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic        f_valid_q, f_valid_d;
    logic [31:0] sk_pc_q, sk_pc_d;
    logic [63:0] sk_inst_q, sk_inst_d;
    logic        sk_valid_q, sk_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [63:0] inst_q, inst_d;
    logic        halted_q, halted_d;
    logic        imem_en;
    logic [IMEM_ADDR_W-1:0] imem_addr;

    always_comb begin
        nxt_d      = nxt_q;
        f_pc_d     = f_pc_q;
        f_valid_d  = f_valid_q;
        sk_pc_d    = sk_pc_q;
        sk_inst_d  = sk_inst_q;
        sk_valid_d = sk_valid_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        halted_d   = halted_q;
        imem_en    = 1'b0;
        imem_addr  = nxt_q[IMEM_ADDR_W-1:0];

        if (rstn && !halted_q) begin
            if (bus.branch_flag) begin
                imem_en    = 1'b1;
                imem_addr  = bus.branch_pc[IMEM_ADDR_W-1:0];
                f_pc_d     = bus.branch_pc;
                f_valid_d  = 1'b1;
                nxt_d      = bus.branch_pc + 32'd1;
                sk_valid_d = 1'b0;
                pc_d       = 32'd0;
                inst_d     = NOP_WORD;
            end else if (bus.interlock) begin
                // Reads are disabled while held, so at most one word ever lands in the skid.
                if (f_valid_q) begin
                    sk_pc_d    = f_pc_q;
                    sk_inst_d  = bus.imem_dout;
                    sk_valid_d = 1'b1;
                end
                f_valid_d = 1'b0;
            end else if (inst_q[63:58] == END_OP) begin
                halted_d   = 1'b1;
                f_valid_d  = 1'b0;
                sk_valid_d = 1'b0;
                pc_d       = 32'd0;
                inst_d     = NOP_WORD;
            end else begin
                imem_en   = 1'b1;
                f_pc_d    = nxt_q;
                f_valid_d = 1'b1;
                nxt_d     = nxt_q + 32'd1;
                // The skid word is older than the in-flight read, so it drains first.
                if (sk_valid_q) begin
                    pc_d       = sk_pc_q;
                    inst_d     = sk_inst_q;
                    sk_valid_d = 1'b0;
                end else if (f_valid_q) begin
                    pc_d   = f_pc_q;
                    inst_d = bus.imem_dout;
                end else begin
                    pc_d   = 32'd0;
                    inst_d = NOP_WORD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            nxt_q      <= RESET_PC;
            f_pc_q     <= 32'd0;
            f_valid_q  <= 1'b0;
            sk_pc_q    <= 32'd0;
            sk_inst_q  <= 64'd0;
            sk_valid_q <= 1'b0;
            pc_q       <= 32'd0;
            inst_q     <= NOP_WORD;
            halted_q   <= 1'b0;
        end else begin
            nxt_q      <= nxt_d;
            f_pc_q     <= f_pc_d;
            f_valid_q  <= f_valid_d;
            sk_pc_q    <= sk_pc_d;
            sk_inst_q  <= sk_inst_d;
            sk_valid_q <= sk_valid_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imem_en   = imem_en;
    assign bus.imem_addr = imem_addr;
    assign bus.pc        = pc_q;
    assign bus.inst      = inst_q;
    assign bus.halted    = halted_q;
endmodule
